// File: rtl/bin_to_digit_codes.sv
// bin_to_digit_codes: iterative double-dabble converter feeding an 8-digit
// seven-segment controller. A start in IDLE loads bin/dp_in. BIN_WIDTH
// shift-add-3 cycles follow, then one FORMAT cycle registers d0..d7, dp and
// overflow and pulses done.
// Ports: clk, reset (sync, active-high), start, bin[BIN_WIDTH], dp_in[8] in;
//        busy, done, overflow, d0..d7[5], dp[8] out.
// Build option: BIN_TO_DIGIT_CODES_LZB_EN enables leading-zero blanking.
module bin_to_digit_codes #(
   parameter int BIN_WIDTH = 27
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [BIN_WIDTH-1:0] bin,
   input  logic [7:0]           dp_in,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow,
   output logic [4:0]           d0,
   output logic [4:0]           d1,
   output logic [4:0]           d2,
   output logic [4:0]           d3,
   output logic [4:0]           d4,
   output logic [4:0]           d5,
   output logic [4:0]           d6,
   output logic [4:0]           d7,
   output logic [7:0]           dp
);

   localparam int SW = 32 + BIN_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FORMAT
   } state_t;

   state_t         state_q, state_d;
   // {bcd[31:0], bin_reg} shifted together as one register
   logic [SW-1:0]  sh_q, sh_d;
   logic [4:0]     cnt_q, cnt_d;
   logic [7:0]     dpc_q, dpc_d;
   logic           ovfp_q, ovfp_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           ovf_q, ovf_d;
   logic [39:0]    dig_q, dig_d;
   logic [7:0]     dp_q, dp_d;

   logic [31:0]    bcd;
   logic [31:0]    adj;
   logic [39:0]    fmt;
   logic           seen;
   logic [3:0]     nib;
   logic [4:0]     code;

   assign bcd = sh_q[SW-1 -: 32];

   // add 3 to each nibble >= 5; nibbles never carry into each other
   always_comb begin
      adj = '0;
      for (int i = 0; i < 8; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = bcd[4*i +: 4];
      end
   end

   // digit codes from the final BCD; walk from the top so blanking
   // stops at the first nonzero digit
   always_comb begin
      fmt  = '0;
      seen = 1'b0;
      nib  = '0;
      code = '0;
      for (int i = 7; i >= 0; i--) begin
         nib  = bcd[4*i +: 4];
         code = {1'b0, nib};
`ifdef BIN_TO_DIGIT_CODES_LZB_EN
         if (!seen && nib == 4'd0 && i != 0)
            code = 5'd23;
`endif
         if (nib != 4'd0)
            seen = 1'b1;
         if (ovfp_q)
            code = 5'd22;
         fmt[5*i +: 5] = code;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      dpc_d   = dpc_q;
      ovfp_d  = ovfp_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      dig_d   = dig_q;
      dp_d    = dp_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = {32'd0, bin};
               dpc_d   = dp_in;
               ovfp_d  = {{(32-BIN_WIDTH){1'b0}}, bin} > 32'd99_999_999;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sh_d  = {adj, sh_q[BIN_WIDTH-1:0]} << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(BIN_WIDTH - 1))
               state_d = FORMAT;
         end
         FORMAT: begin
            dig_d   = fmt;
            dp_d    = dpc_q;
            ovf_d   = ovfp_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         dpc_q   <= '0;
         ovfp_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dig_q   <= '0;
         dp_q    <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         dpc_q   <= dpc_d;
         ovfp_q  <= ovfp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         dig_q   <= dig_d;
         dp_q    <= dp_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign dp       = dp_q;
   assign d0       = dig_q[4:0];
   assign d1       = dig_q[9:5];
   assign d2       = dig_q[14:10];
   assign d3       = dig_q[19:15];
   assign d4       = dig_q[24:20];
   assign d5       = dig_q[29:25];
   assign d6       = dig_q[34:30];
   assign d7       = dig_q[39:35];

endmodule

// File: tb/tb_bin_to_digit_codes.sv
// Bench for bin_to_digit_codes: decimal reference model checked every cycle
// plus directed vectors with literal expected digit codes.
module tb_bin_to_digit_codes;

   localparam int BW = 27;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [BW-1:0] bin = '0;
   logic [7:0]    dp_in = '0;
   wire           busy, done, overflow;
   wire  [4:0]    d0, d1, d2, d3, d4, d5, d6, d7;
   wire  [7:0]    dp;
   wire  [39:0]   dall = {d7, d6, d5, d4, d3, d2, d1, d0};

   int compared = 0;
   int mismatched = 0;

   bin_to_digit_codes #(.BIN_WIDTH(BW)) dut (
      .clk(clk), .reset(reset), .start(start), .bin(bin), .dp_in(dp_in),
      .busy(busy), .done(done), .overflow(overflow),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .d4(d4), .d5(d5), .d6(d6), .d7(d7), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // decimal digits by division; codes 22 = dash, 23 = blank
   function automatic logic [39:0] exp_codes(input int unsigned v);
      logic [39:0] r;
      int unsigned t;
      int msd;
      r = '0;
      t = v;
      msd = 0;
      if (v > 99_999_999) return {8{5'd22}};
      for (int i = 0; i < 8; i++) begin
         r[5*i +: 5] = 5'(t % 10);
         if (t % 10 != 0) msd = i;
         t = t / 10;
      end
`ifdef BIN_TO_DIGIT_CODES_LZB_EN
      for (int i = 1; i < 8; i++)
         if (i > msd) r[5*i +: 5] = 5'd23;
`endif
      return r;
   endfunction

   // transaction-level model: a request is accepted when nothing is
   // pending and its result appears BW+1 edges later
   bit          m_valid = 0;
   bit          m_pend = 0;
   int          m_rem = 0;
   int unsigned m_val = 0;
   logic [7:0]  m_dpin = '0;
   logic        m_busy = 0, m_done = 0, m_ovf = 0;
   logic [39:0] m_d = '0;
   logic [7:0]  m_dp = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_valid = 1;
         m_pend = 0;
         m_busy = 0;
         m_done = 0;
         m_ovf = 0;
         m_d = '0;
         m_dp = '0;
      end else begin
         m_done = 0;
         if (m_pend) begin
            m_rem--;
            if (m_rem == 0) begin
               m_pend = 0;
               m_done = 1;
               m_d = exp_codes(m_val);
               m_ovf = m_val > 99_999_999;
               m_dp = m_dpin;
            end
         end else if (start) begin
            m_pend = 1;
            m_rem = BW + 1;
            m_val = int'(bin);
            m_dpin = dp_in;
         end
         m_busy = m_pend;
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         chk("busy", 64'(busy), 64'(m_busy));
         chk("done", 64'(done), 64'(m_done));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("digits", 64'(dall), 64'(m_d));
         chk("dp", 64'(dp), 64'(m_dp));
      end
   end

   // start a conversion and wait for done; optionally retrigger start
   // 10 cycles in with another value, which must be ignored
   task automatic run_conv(input int unsigned v, input logic [7:0] p,
                           input bit inj, input int unsigned v2,
                           output int lat);
      int n;
      @(negedge clk);
      bin = v[BW-1:0];
      dp_in = p;
      start = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         if (n == 0) start = 1'b0;
         if (inj && n == 10) begin
            bin = v2[BW-1:0];
            start = 1'b1;
         end
         if (inj && n == 11) start = 1'b0;
         n++;
         if (done) break;
      end
      if (!done) chk("done_seen", 64'd0, 64'd1);
      lat = n - 1;
   endtask

   int lat;
   int dcount;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_digits", 64'(dall), 64'd0);
      chk("rst_dp", 64'(dp), 64'd0);

      run_conv(12_345_678, 8'h04, 0, 0, lat);
      chk("lat_12345678", 64'(lat), 64'd28);
      chk("dig_12345678", 64'(dall),
          64'({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}));
      chk("dp_12345678", 64'(dp), 64'h04);
      chk("ovf_12345678", 64'(overflow), 64'd0);

      run_conv(99_999_999, 8'hA5, 0, 0, lat);
      chk("dig_max", 64'(dall), 64'({8{5'd9}}));
      chk("ovf_max", 64'(overflow), 64'd0);
      chk("dp_max", 64'(dp), 64'hA5);

      run_conv(100_000_000, 8'h00, 0, 0, lat);
      chk("dig_ovf", 64'(dall), 64'({8{5'd22}}));
      chk("ovf_ovf", 64'(overflow), 64'd1);
      chk("lat_ovf", 64'(lat), 64'd28);

      run_conv(305, 8'h80, 0, 0, lat);
`ifdef BIN_TO_DIGIT_CODES_LZB_EN
      chk("dig_305", 64'(dall),
          64'({{5{5'd23}}, 5'd3, 5'd0, 5'd5}));
`else
      chk("dig_305", 64'(dall),
          64'({{5{5'd0}}, 5'd3, 5'd0, 5'd5}));
`endif

      run_conv(0, 8'h01, 0, 0, lat);
`ifdef BIN_TO_DIGIT_CODES_LZB_EN
      chk("dig_0", 64'(dall), 64'({{7{5'd23}}, 5'd0}));
`else
      chk("dig_0", 64'(dall), 64'd0);
`endif
      chk("dp_0", 64'(dp), 64'h01);

      run_conv(87_654_321, 8'h10, 1, 5555, lat);
      chk("lat_inj", 64'(lat), 64'd28);
      chk("dig_inj", 64'(dall),
          64'({5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));

      run_conv((1 << BW) - 1, 8'h00, 0, 0, lat);
      chk("dig_full", 64'(dall), 64'({8{5'd22}}));
      chk("ovf_full", 64'(overflow), 64'd1);

      run_conv(40_302_010, 8'hFF, 0, 0, lat);
      @(negedge clk);
      bin = 27'd123;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
      end
      chk("abort_no_done", 64'(dcount), 64'd0);
      chk("abort_digits", 64'(dall), 64'd0);
      chk("abort_dp", 64'(dp), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);

      run_conv(7, 8'h02, 0, 0, lat);
      chk("lat_after", 64'(lat), 64'd28);
`ifdef BIN_TO_DIGIT_CODES_LZB_EN
      chk("dig_after", 64'(dall), 64'({{7{5'd23}}, 5'd7}));
`else
      chk("dig_after", 64'(dall), 64'd7);
`endif
      chk("dp_after", 64'(dp), 64'h02);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bin_to_digit_codes.md
# bin_to_digit_codes

Sequential binary-to-display-code converter that sits directly upstream of the 8-digit seven-segment controller. It accepts an unsigned binary value on a start strobe and runs an iterative double-dabble (shift-add-3) conversion. It then drives the controller's eight 5-bit digit codes and 8-bit decimal-point vector. Results are registered and held stable until the next conversion completes, so the display never shows intermediate values.

## Interface
Parameters:
- BIN_WIDTH, 27, width of the binary input; legal range 4..27.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_WIDTH  unsigned value to convert; sampled with start.
- dp_in  input  8  decimal-point pattern; sampled with start; bit i belongs to digit i.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; new outputs are valid in this cycle.
- overflow  output  1  high when the last converted value exceeded 99,999,999.
- d0..d7  output  5 each  digit codes for the controller; d0 is the least-significant (rightmost) digit.
- dp  output  8  decimal points for the controller.

## Operation
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE, start=1:
  - load bin, zero-extended, into a shift register;
  - clear the 32-bit BCD accumulator;
  - capture dp_in;
  - set ovf_pending = (bin > 99_999_999);
  - iteration counter <= 0; busy <= 1; go to SHIFT.
- IDLE, start=0: hold.
- SHIFT, one iteration per cycle:
  - add 3 to every BCD nibble that is >= 5;
  - shift {BCD, bin_reg} left by one.
- SHIFT runs exactly BIN_WIDTH iterations, then goes to FORMAT.
- FORMAT, single cycle:
  - register d0..d7 from BCD nibbles 0..7, values 0-9;
  - register dp and overflow;
  - done <= 1; busy <= 0; return to IDLE.
- Overflow: all d0..d7 = 22 (segment g, dash display); overflow = 1. Latency is unchanged.
- start while busy is ignored. There is no queuing.
- Outputs d*/dp/overflow change only at FORMAT and hold otherwise.
- Reset mid-conversion aborts the conversion and forces reset values. No done pulse is issued.
- Arithmetic:
  - BCD accumulator is 32 bits;
  - add-3 is per 4-bit nibble, with no carry between nibbles;
  - BIN_WIDTH < 27 simply yields zero upper digits.

## Timing
- Reset values:
  - state IDLE; busy 0; done 0; overflow 0;
  - d0..d7 = 0; dp = 8'h00.
- Start accepted at clock edge E0 → SHIFT occupies edges E1..E(BIN_WIDTH) → FORMAT at edge E(BIN_WIDTH+1).
- done is high for exactly the one cycle after edge E(BIN_WIDTH+1). For the default this is E28.
- busy is high from after E0 through the cycle before done; it is low while done is high.
- A new start is accepted in the same cycle done is high, giving back-to-back throughput of one result per BIN_WIDTH+2 cycles.
- start and reset asserted in the same cycle: reset wins.

## Configuration
- Macro BIN_TO_DIGIT_CODES_LZB_EN enables leading-zero blanking.
- When defined, FORMAT replaces with code 23 (blank) every zero digit above the most-significant nonzero digit.
  - d0 is never blanked; a value of 0 displays a single "0".
  - dp bits are unaffected.
  - The overflow dash pattern is not blanked.
- When undefined, all eight digits show their numeric code, including leading zeros.
- Latency is identical in both builds.

## Test plan
- Reset, then idle 5 cycles → busy=0, done=0, overflow=0, d0..d7=0, dp=0.
- bin=12_345_678, dp_in=8'h04, start → done exactly 28 cycles after the start edge; d7..d0 = 1,2,3,4,5,6,7,8; dp=8'h04; overflow=0.
- bin=99_999_999 → all digits 9, overflow=0. Then bin=100_000_000 → all digits 22, overflow=1.
- LZB build, bin=305 → d2..d0 = 3,0,5, d7..d3 = 23. bin=0 → d0=0, others 23. Non-LZB build, bin=305 → d7..d3 = 0.
- Pulse start again 10 cycles into a conversion with a different bin → ignored; result matches the first value.
- Reset asserted mid-conversion → no done pulse; outputs at reset values; next start converts correctly.
